seq_multiplier: RTL and testbench

- Iterative shift-add 64x64 unsigned multiplier for the CPU execute path. Produces MUL (low 64 bits) or UMULH (high 64 bits).
- Its result, write pulse and destination tag drive a downstream 64-bit register's data_in and write_enable directly.
- Occupies the unit for multiple cycles; start/busy/done handshake to the control unit.

---
 rtl/seq_mul_pkg.sv | 9 +
 rtl/seq_multiplier_mul_step.sv | 23 ++
 rtl/seq_multiplier.sv | 106 ++++++++++
 tb/tb_seq_multiplier.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   localparam int MUL_WIDTH_DEFAULT = 64;
   localparam int TAG_W             = 5;

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the high half,
// then shift the (2*WIDTH+1)-bit {carry, prod_hi, prod_lo} right by one.
module mul_step
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] prod_hi,
   input  logic [WIDTH-1:0] prod_lo,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum     = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], prod_lo[WIDTH-1:1]};
   end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned WIDTHxWIDTH multiplier returning the low (MUL) or high (UMULH) half.
// Define SEQ_MULTIPLIER_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module seq_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             high_sel,
   input  logic [TAG_W-1:0] rd_in,
   output logic             busy,
   output logic             done,
   output logic             wr_en,
   output logic [TAG_W-1:0] rd_out,
   output logic [WIDTH-1:0] result
);

   mul_state_t       state, next_state;
   logic [WIDTH-1:0] prod_hi, prod_lo, mcand;
   logic [WIDTH-1:0] step_hi, step_lo, upd_hi, upd_lo;
   logic [CNT_W-1:0] count;
   logic             high_sel_q;
   logic [TAG_W-1:0] tag_q;
   logic             last;

   mul_step #(.WIDTH(WIDTH)) u_step (
      .prod_hi (prod_hi),
      .prod_lo (prod_lo),
      .mcand   (mcand),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
   logic [WIDTH-1:0] live_mask;
`endif

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      upd_hi     = step_hi;
      upd_lo     = step_lo;
      last       = (count == CNT_W'(1));
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
      // The low `count` bits of prod_lo are the multiplier bits not yet consumed.
      for (int i = 0; i < WIDTH; i++) live_mask[i] = (i < int'(count));
      if ((prod_lo & live_mask) == '0) begin
         {upd_hi, upd_lo} = {prod_hi, prod_lo} >> count;
         last             = 1'b1;
      end
`endif
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = BUSY;
         BUSY:    if (last)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prod_hi    <= '0;
         prod_lo    <= '0;
         mcand      <= '0;
         count      <= '0;
         high_sel_q <= 1'b0;
         tag_q      <= '0;
         result     <= '0;
         rd_out     <= '0;
      end else if (state == IDLE && next_state == BUSY) begin
         prod_hi    <= '0;
         prod_lo    <= op_b;
         mcand      <= op_a;
         high_sel_q <= high_sel;
         tag_q      <= rd_in;
         count      <= CNT_W'(WIDTH);
      end else if (state == BUSY && !flush) begin
         prod_hi <= upd_hi;
         prod_lo <= upd_lo;
         count   <= count - CNT_W'(1);
         // Outputs are committed only on the edge that enters DONE; a flush leaves them untouched.
         if (next_state == DONE) begin
            result <= high_sel_q ? upd_hi : upd_lo;
            rd_out <= tag_q;
         end
      end
   end

   assign busy  = (state != IDLE);
   assign done  = (state == DONE);
   assign wr_en = done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier with a result scoreboard.
module tb_seq_multiplier;

   localparam int W = 64;

   typedef struct {
      logic [W-1:0] res;
      logic [4:0]   rd;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         start, flush, high_sel;
   logic [W-1:0] op_a, op_b;
   logic [4:0]   rd_in;
   logic         busy, done, wr_en;
   logic [4:0]   rd_out;
   logic [W-1:0] result;

   exp_t         sb[$];
   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] last_res = '0;
   logic [4:0]   last_rd  = '0;

   always #5 clk = ~clk;

   seq_multiplier dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .flush    (flush),
      .op_a     (op_a),
      .op_b     (op_b),
      .high_sel (high_sel),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .wr_en    (wr_en),
      .rd_out   (rd_out),
      .result   (result)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Number of BUSY cycles the bench expects for a given multiplier operand.
   function automatic int exp_busy(input logic [W-1:0] b);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
      int h = -1;
      for (int i = 0; i < W; i++) if (b[i]) h = i;
      if (h < 0) return 1;
      if (h >= W - 2) return W;
      return h + 2;
`else
      return W;
`endif
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic hs,
                        input logic [4:0] rd, input bit push);
      logic [127:0] prod;
      exp_t         e;
      @(negedge clk);
      op_a = a; op_b = b; high_sel = hs; rd_in = rd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Scramble operands after acceptance to prove they were captured.
      op_a = ~a; op_b = ~b; high_sel = ~hs; rd_in = ~rd;
      if (push) begin
         prod  = {64'b0, a} * {64'b0, b};
         e.res = hs ? prod[127:64] : prod[63:0];
         e.rd  = rd;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done(input string tag, input int exp_cyc, input int poke_at,
                            input bit poke_in_done);
      int   cyc      = 0;
      bit   busy_low = 0;
      exp_t e;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy !== 1'b1) busy_low = 1;
         if (cyc == poke_at) begin
            start = 1'b1; op_a = 2; op_b = 2; rd_in = 5'd3;
         end else start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, "_busy_cycles"}, cyc, exp_cyc);
      check({tag, "_busy_held"}, busy_low, 0);
      check({tag, "_done_busy_wr"}, {busy, done, wr_en}, 3'b111);
      if (sb.size() > 0) e = sb.pop_front();
      else begin
         e.res = 'x;
         e.rd  = 'x;
      end
      check({tag, "_result"}, result, e.res);
      check({tag, "_rd_out"}, rd_out, e.rd);
      last_res = e.res;
      last_rd  = e.rd;
      if (poke_in_done) begin
         start = 1'b1; op_a = 2; op_b = 2; rd_in = 5'd3;
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_after"}, {busy, done, wr_en}, 3'b000);
      check({tag, "_result_held"}, result, last_res);
   endtask

   task automatic watch_no_write(input string tag, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (wr_en !== 1'b0 || busy !== 1'b0) pulses++;
      end
      check(tag, pulses, 0);
   endtask

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
   localparam int FLUSH_AT = 3;
`else
   localparam int FLUSH_AT = 10;
`endif

   initial begin
      reset_n = 1'b0; start = 1'b0; flush = 1'b0; high_sel = 1'b0;
      op_a = '0; op_b = '0; rd_in = '0;
      repeat (2) @(negedge clk);
      check("reset_ctrl", {busy, done, wr_en}, 3'b000);
      check("reset_result", result, 0);
      check("reset_rd", rd_out, 0);
      reset_n = 1'b1;

      // Basic MUL
      issue(3, 5, 1'b0, 5'd9, 1);
      wait_done("mul_3x5", exp_busy(5), -1, 0);

      // UMULH / MUL of all-ones operands
      issue('1, '1, 1'b1, 5'd1, 1);
      wait_done("umulh_ones", exp_busy('1), -1, 0);
      issue('1, '1, 1'b0, 5'd2, 1);
      wait_done("mul_ones", exp_busy('1), -1, 0);

      // Start during BUSY and during DONE is ignored; then a fresh start works
      issue(6, 7, 1'b0, 5'd7, 1);
      wait_done("ignored_start", exp_busy(7), 2, 1);
      issue(2, 2, 1'b0, 5'd3, 1);
      wait_done("mul_2x2", exp_busy(2), -1, 0);

      // Flush mid-operation: no write, outputs keep previous values
      issue(9, 9, 1'b0, 5'd4, 0);
      repeat (FLUSH_AT - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ctrl", {busy, done, wr_en}, 3'b000);
      check("flush_result", result, last_res);
      check("flush_rd", rd_out, last_rd);
      watch_no_write("flush_no_write", 80);
      issue(10, 11, 1'b0, 5'd12, 1);
      wait_done("after_flush", exp_busy(11), -1, 0);

      // Early-termination corner operands (full length in the default build)
      issue(77, 0, 1'b0, 5'd13, 1);
      wait_done("op_b_zero", exp_busy(0), -1, 0);
      issue(123, 1, 1'b0, 5'd14, 1);
      wait_done("op_b_one", exp_busy(1), -1, 0);
      issue(64'hDEAD_BEEF_0000_0003, 64'h8000_0000_0000_0000, 1'b1, 5'd15, 1);
      wait_done("op_b_msb", exp_busy(64'h8000_0000_0000_0000), -1, 0);

      // Asynchronous reset mid-BUSY
      issue(5, 7, 1'b0, 5'd11, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rst_mid_ctrl", {busy, done, wr_en}, 3'b000);
      check("rst_mid_result", result, 0);
      check("rst_mid_rd", rd_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      watch_no_write("rst_no_write", 80);

      // Generic operands after reset
      issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 5'd31, 1);
      wait_done("mixed_hi", exp_busy(64'hFEDC_BA98_7654_3210), -1, 0);
      issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 5'd30, 1);
      wait_done("mixed_lo", exp_busy(64'hFEDC_BA98_7654_3210), -1, 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
